halt_sequencer: RTL

Sequential halt controller downstream of the combinational halt check (`ecall` with `x17 == 10`). It freezes instruction fetch on the cycle the halting `ecall` commits, then drains outstanding data-memory writes for a fixed window. Only after the drain does it assert a sticky `is_halted` to the testbench. It also keeps cycle and retired-instruction counters for end-of-run reporting.

---
 rtl/halt_sequencer_pkg.sv | 8 +
 rtl/halt_sequencer_sat_counter.sv | 14 +
 rtl/halt_sequencer.sv | 60 ++++++
 3 files changed

// File: rtl/halt_sequencer_pkg.sv
// halt_sequencer_pkg: shared state encoding for the halt sequencer
package halt_sequencer_pkg;
   typedef enum logic [1:0] {
      HS_RUN    = 2'd0,
      HS_DRAIN  = 2'd1,
      HS_HALTED = 2'd2
   } hs_state_t;
endpackage

// File: rtl/halt_sequencer_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);
   // count enabled events, holding at the maximum value
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/halt_sequencer.sv
// halt_sequencer: freezes fetch on a halting ecall, drains memory writes, then flags halted
module halt_sequencer
   import halt_sequencer_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst_valid,
   input  logic             halt_req,
   input  logic             mem_busy,
   output logic             pc_write_en,
   output logic             is_halted,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count
);
   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   hs_state_t     state;
   logic [DW-1:0] drain_cnt;
   logic          halt_commit;
   assign halt_commit = inst_valid & halt_req;
   assign pc_write_en = (state == HS_RUN) & ~halt_commit;
   // run/drain/halted sequencing; the unused encoding falls into HALTED
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= HS_RUN;
         drain_cnt <= '0;
         is_halted <= 1'b0;
      end else
         case (state)
            HS_RUN:
               if (halt_commit) begin
                  state     <= HS_DRAIN;
                  drain_cnt <= DW'(DRAIN_CYCLES);
               end
            HS_DRAIN:
               if (drain_cnt == '0 && !mem_busy) begin
                  state     <= HS_HALTED;
                  is_halted <= 1'b1;
               end else if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
            HS_HALTED: is_halted <= 1'b1;
            default: begin
               state     <= HS_HALTED;
               is_halted <= 1'b1;
            end
         endcase
   sat_counter #(.W(CNT_W)) u_cycle (
      .clk  (clk),
      .reset(reset),
      .en   (state != HS_HALTED),
      .count(cycle_count)
   );
   sat_counter #(.W(CNT_W)) u_retired (
      .clk  (clk),
      .reset(reset),
      .en   ((state == HS_RUN) & inst_valid),
      .count(retired_count)
   );
endmodule
